// File: rtl/adder_tree_operand_feeder_if.sv
// Handshake and operand/result bus between the adder-tree feeder and its environment.
// master: the feeder itself; slave: the byte producer, tree and result consumer side.
interface adder_tree_operand_feeder_if #(
  parameter int DATA_W  = 8,
  parameter int N_LANES = 16,
  parameter int SUM_W   = 16
);
  logic [DATA_W-1:0]         in_data;
  logic                      in_valid;
  logic                      in_ready;
  logic [N_LANES*DATA_W-1:0] opnd_bus;
  logic                      tree_launch;
  logic [SUM_W-1:0]          sum_in;
  logic [SUM_W-1:0]          out_sum;
  logic                      out_valid;
  logic                      out_ready;
  logic                      busy;
  logic [15:0]               result_count;

  modport master (
    input  in_data, in_valid, sum_in, out_ready,
    output in_ready, opnd_bus, tree_launch, out_sum, out_valid, busy, result_count
  );

  modport slave (
    output in_data, in_valid, sum_in, out_ready,
    input  in_ready, opnd_bus, tree_launch, out_sum, out_valid, busy, result_count
  );
endinterface

// File: rtl/adder_tree_operand_feeder.sv
// Packs a byte stream into the operand lanes of a fixed-latency adder tree, waits for the
// tree to drain, captures its sum and offers it on a valid/ready result port.
module adder_tree_operand_feeder #(
  parameter int LATENCY = 4,
  parameter int N_LANES = 16,
  parameter int DATA_W  = 8,
  parameter int SUM_W   = 16
) (
  input logic                          clk,
  input logic                          reset,
  adder_tree_operand_feeder_if.master  bus
);
  localparam int IDX_W = $clog2(N_LANES);
  localparam int CNT_W = $clog2(LATENCY + 2);

  typedef enum logic [1:0] {FILL, WAIT, OUT} state_t;

  state_t                    state;
  logic [IDX_W-1:0]          idx;
  logic [CNT_W-1:0]          wait_cnt;
  logic [N_LANES*DATA_W-1:0] opnd;
  logic [SUM_W-1:0]          sum_p1;
  logic                      vld_p1;
  logic                      tree_launch;
  logic [15:0]               result_count;
  logic                      accept;

  assign bus.in_ready     = (state == FILL) && !reset;
  assign accept           = bus.in_valid && bus.in_ready;
  assign bus.opnd_bus     = opnd;
  assign bus.tree_launch  = tree_launch;
  assign bus.out_sum      = sum_p1;
  assign bus.out_valid    = vld_p1;
  assign bus.busy         = (state != FILL);
  assign bus.result_count = result_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= FILL;
      idx          <= '0;
      wait_cnt     <= '0;
      opnd         <= '0;
      sum_p1       <= '0;
      vld_p1       <= 1'b0;
      tree_launch  <= 1'b0;
      result_count <= '0;
    end else begin
      tree_launch <= 1'b0;
      case (state)
        FILL: begin
          if (accept) begin
            opnd[idx*DATA_W +: DATA_W] <= bus.in_data;
            idx                        <= idx + 1'b1;
            if (idx == IDX_W'(N_LANES - 1)) begin
              state       <= WAIT;
              wait_cnt    <= '0;
              tree_launch <= 1'b1;
            end
          end
        end
        // Operands stay frozen; sum_in is trusted only after LATENCY+1 stable cycles
        WAIT: begin
          if (wait_cnt == CNT_W'(LATENCY)) begin
            sum_p1 <= bus.sum_in;
            vld_p1 <= 1'b1;
            state  <= OUT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        OUT: begin
          if (vld_p1 && bus.out_ready) begin
            vld_p1       <= 1'b0;
            result_count <= result_count + 16'd1;
            idx          <= '0;
            state        <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end
endmodule
